// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and BRAM port of the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_misaligned;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_misaligned,
               mem_read_enable, mem_write_enable, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_misaligned,
               mem_read_enable, mem_write_enable, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one word-wide BRAM between fetch and load/store, with RMW sub-word stores
module mem_arbiter #(
    parameter int ADDR_W = 7
) (
    input logic         clock,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, I_RESP, D_RESP, RMW_WR, D_ACK, ERR} state_t;

    state_t            state;
    logic              rr_last_d;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              idle;
    logic              pick_d;
    logic              pick_i;
    logic              d_err;
    logic              d_sw;
    logic [4:0]        shamt;
    logic [31:0]       lane;
    logic [31:0]       mask;
    logic [31:0]       merged;
    logic [31:0]       load_val;
    logic              unused_bits;

    assign unused_bits = ^{bus.i_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2], lane[31:16]};

    // Arbitration, access legality, load formatting and RMW merge
    always_comb begin
        idle     = state == IDLE && reset;
        pick_d   = idle && bus.d_req && (!bus.i_req || !rr_last_d);
        pick_i   = idle && bus.i_req && !pick_d;
        d_err    = (bus.d_we ? bus.d_funct3 > 3'd2
                             : !(bus.d_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
                || (bus.d_funct3[1:0] == 2'b01 && bus.d_addr[0])
                || (bus.d_funct3[1:0] == 2'b10 && bus.d_addr[1:0] != 2'b00);
        d_sw     = bus.d_we && bus.d_funct3 == 3'b010;
        shamt    = {addr_q[1:0], 3'b000};
        lane     = bus.mem_rdata >> shamt;
        mask     = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
        merged   = (bus.mem_rdata & ~mask) | ((wdata_q << shamt) & mask);
        load_val = f3_q[1] ? bus.mem_rdata
                 : f3_q[0] ? {{16{lane[15] & ~f3_q[2]}}, lane[15:0]}
                 : {{24{lane[7] & ~f3_q[2]}}, lane[7:0]};
    end

    // Grants and BRAM controls are live in the grant cycle; responses decode from state
    always_comb begin
        bus.i_gnt            = pick_i;
        bus.d_gnt            = pick_d;
        bus.mem_read_enable  = pick_i || (pick_d && !d_err && !d_sw);
        bus.mem_write_enable = (pick_d && !d_err && d_sw) || state == RMW_WR;
        bus.mem_addr         = pick_i ? bus.i_addr[ADDR_W+1:2]
                             : pick_d ? bus.d_addr[ADDR_W+1:2]
                             : state == RMW_WR ? addr_q[ADDR_W+1:2] : '0;
        bus.mem_wdata        = (pick_d && !d_err && d_sw) ? bus.d_wdata
                             : state == RMW_WR ? merged : '0;
        bus.i_rvalid         = state == I_RESP;
        bus.i_rdata          = state == I_RESP ? bus.mem_rdata : '0;
        bus.d_rvalid         = state inside {D_RESP, D_ACK, ERR};
        bus.d_rdata          = state == D_RESP ? load_val : '0;
        bus.d_misaligned     = state == ERR;
    end

    // Sequencer: capture the winner's request and walk the access through its response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_last_d <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            wdata_q   <= '0;
        end else begin
            if (pick_i || pick_d) begin
                rr_last_d <= pick_d;
                addr_q    <= pick_d ? bus.d_addr[ADDR_W+1:0] : bus.i_addr[ADDR_W+1:0];
            end
            if (pick_d) begin
                f3_q    <= bus.d_funct3;
                wdata_q <= bus.d_wdata;
            end
            state <= pick_i ? I_RESP
                   : pick_d ? (d_err ? ERR : !bus.d_we ? D_RESP : d_sw ? D_ACK : RMW_WR)
                   : state == RMW_WR ? D_ACK : IDLE;
        end
    end
endmodule
